led_tick_gen: RTL and testbench
===============================

LED_TICK_GEN -- requirements
Module: LED_TICK_GEN

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 40000000: system clock frequency.
REQ-002 SHALL have parameter TICK_HZ, default 10: frequency of CLK_10HZ.
REQ-003 SHALL have parameter STRETCH_TICKS, default 2: activity-LED hold length in ticks; legal range 1..15.
REQ-004 SHALL have port CLK, input, 1 bit: system clock; all logic on its rising edge, one clock domain.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port ENABLE, input, 1 bit: divider run enable.
REQ-007 SHALL have port TX_ACT_IN, input, 1 bit: TX activity strobe, synchronous to CLK.
REQ-008 SHALL have port RX_ACT_IN, input, 1 bit: RX activity strobe, synchronous to CLK.
REQ-009 SHALL have port CLK_10HZ, output, 1 bit: 50% duty square wave at TICK_HZ; feeds the LED controller clock.
REQ-010 SHALL have port TICK_10HZ, output, 1 bit: one-CLK pulse per CLK_10HZ rising transition.
REQ-011 SHALL have port TICK_1HZ, output, 1 bit: one-CLK pulse on every 10th TICK_10HZ.
REQ-012 SHALL have ports TX_ACT_LED and RX_ACT_LED, output, 1 bit each: stretched activity indicators.

Function
REQ-013 SHALL use HALF = CLK_FREQ_HZ/(2*TICK_HZ); HALF >= 2 and exact division are required; divider counter width = clog2(HALF).
REQ-014 SHALL, while ENABLE=1, increment the divider each CLK; when it equals HALF-1 it wraps to 0 and CLK_10HZ toggles on the same edge.
REQ-015 SHALL assert TICK_10HZ for exactly the one CLK cycle in which CLK_10HZ first reads 1 after a 0->1 toggle; no pulse on the 1->0 toggle.
REQ-016 SHALL keep a mod-10 tick counter; on the 10th TICK_10HZ it wraps and asserts TICK_1HZ in the same cycle as that TICK_10HZ.
REQ-017 SHALL, while ENABLE=0, hold the divider, CLK_10HZ and the mod-10 counter; TICK_10HZ and TICK_1HZ are 0. Counting resumes from the held value with no lost or extra edge.
REQ-018 SHALL give each of TX and RX a 4-bit stretch counter; ACT_IN=1 at an edge loads STRETCH_TICKS.
REQ-019 SHALL, when ACT_IN=0 and TICK_10HZ=1 at an edge, decrement a non-zero stretch counter; a zero counter stays 0.
REQ-020 SHALL give ACT_IN priority over TICK_10HZ on the same edge: reload, no decrement.
REQ-021 SHALL register the ACT_LED output as (next stretch count != 0), so the LED rises one CLK after the ACT_IN sample and falls on the edge where the count reaches 0.
REQ-022 SHALL register all outputs; no combinational path from any input to any output.
REQ-023 SHALL keep stretchers loading on ACT_IN when ENABLE=0; they do not decrement because no ticks occur.

Reset
REQ-024 SHALL, on an edge with RST=1, clear the divider, mod-10 counter and stretch counters to 0, and drive CLK_10HZ, TICK_10HZ, TICK_1HZ, TX_ACT_LED and RX_ACT_LED to 0.
REQ-025 SHALL give RST priority over ENABLE and ACT_IN; reset mid-period discards phase, and the first post-reset period is full length.

Verification (CLK_FREQ_HZ=100, TICK_HZ=10, HALF=5, STRETCH_TICKS=2; edge n = nth CLK edge after RST deasserts)
REQ-026 SHALL cover free run with ENABLE=1 -> CLK_10HZ=0 through edge 4, 1 after edge 5, 0 after edge 10, period 10; TICK_10HZ high only after edges 5, 15, 25, ...
REQ-027 SHALL cover free run for 200 edges -> TICK_1HZ high only after edges 95 and 195, coincident with TICK_10HZ.
REQ-028 SHALL cover ENABLE=0 sampled at edges 2-4 -> CLK_10HZ rises after edge 8; no tick pulses while disabled.
REQ-029 SHALL cover a one-cycle TX_ACT_IN sampled at edge 7 -> TX_ACT_LED=1 after edge 7, still 1 after edge 16, 0 after edge 26; RX_ACT_LED stays 0.
REQ-030 SHALL cover RX_ACT_IN sampled at edge 16, while TICK_10HZ=1 -> count reloads to 2 (no decrement); RX_ACT_LED falls after edge 36.
REQ-031 SHALL cover RST=1 for one edge while CLK_10HZ=1 and TX_ACT_LED=1 -> all outputs 0 after that edge; the next sequence matches REQ-026.

Source files
------------

// File: rtl/led_tick_gen.sv
// LED tick generator: divides the system clock down to a TICK_HZ square wave,
// derives one-cycle tick strobes at TICK_HZ and TICK_HZ/10, and stretches
// short TX/RX activity strobes into LED-visible pulses measured in ticks.
module led_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ   = 40000000,
    parameter int unsigned TICK_HZ       = 10,
    parameter int unsigned STRETCH_TICKS = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic ENABLE,
    input  logic TX_ACT_IN,
    input  logic RX_ACT_IN,
    output logic CLK_10HZ,
    output logic TICK_10HZ,
    output logic TICK_1HZ,
    output logic TX_ACT_LED,
    output logic RX_ACT_LED
);

    localparam int unsigned HALF      = CLK_FREQ_HZ / (2 * TICK_HZ);
    localparam int unsigned DIV_W     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned STR_W     = 4;
    localparam int unsigned MOD_W     = 4;
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(HALF - 1);
    localparam logic [STR_W-1:0] STRETCH_LOAD = STR_W'(STRETCH_TICKS);
    localparam logic [MOD_W-1:0] MOD_LAST     = MOD_W'(9);

    // Elaboration-time guard on parameter legality
    if (HALF < 2 || (HALF * 2 * TICK_HZ) != CLK_FREQ_HZ ||
        STRETCH_TICKS < 1 || STRETCH_TICKS > 15) begin : g_param_check
        $error("led_tick_gen: illegal CLK_FREQ_HZ/TICK_HZ/STRETCH_TICKS combination");
    end

    logic [DIV_W-1:0] div_q,    div_d;
    logic             clk10_q,  clk10_d;
    logic             tick10_q, tick10_d;
    logic             tick1_q,  tick1_d;
    logic [MOD_W-1:0] mod10_q,  mod10_d;
    logic [STR_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [STR_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             tx_led_q, tx_led_d;
    logic             rx_led_q, rx_led_d;

    // Activity strobe reloads; otherwise a registered tick decrements toward zero
    function automatic logic [STR_W-1:0] stretch_next(input logic act,
                                                      input logic tick,
                                                      input logic [STR_W-1:0] cnt);
        logic [STR_W-1:0] nxt;
        nxt = cnt;
        if (act) begin
            nxt = STRETCH_LOAD;
        end else if (tick && cnt != '0) begin
            nxt = cnt - STR_W'(1);
        end
        return nxt;
    endfunction

    // Divider, square wave, tick strobes and stretch next-state
    always_comb begin
        div_d    = div_q;
        clk10_d  = clk10_q;
        tick10_d = 1'b0;
        tick1_d  = 1'b0;
        mod10_d  = mod10_q;

        if (ENABLE) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                clk10_d = ~clk10_q;
                // Strobe only on the rising half of the square wave
                if (!clk10_q) begin
                    tick10_d = 1'b1;
                    if (mod10_q == MOD_LAST) begin
                        mod10_d = '0;
                        tick1_d = 1'b1;
                    end else begin
                        mod10_d = mod10_q + MOD_W'(1);
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        tx_cnt_d = stretch_next(TX_ACT_IN, tick10_q, tx_cnt_q);
        rx_cnt_d = stretch_next(RX_ACT_IN, tick10_q, rx_cnt_q);
        tx_led_d = (tx_cnt_d != '0);
        rx_led_d = (rx_cnt_d != '0);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q    <= '0;
            clk10_q  <= 1'b0;
            tick10_q <= 1'b0;
            tick1_q  <= 1'b0;
            mod10_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tx_led_q <= 1'b0;
            rx_led_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            clk10_q  <= clk10_d;
            tick10_q <= tick10_d;
            tick1_q  <= tick1_d;
            mod10_q  <= mod10_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_led_q <= tx_led_d;
            rx_led_q <= rx_led_d;
        end
    end

    assign CLK_10HZ   = clk10_q;
    assign TICK_10HZ  = tick10_q;
    assign TICK_1HZ   = tick1_q;
    assign TX_ACT_LED = tx_led_q;
    assign RX_ACT_LED = rx_led_q;

endmodule

// File: tb/tb_led_tick_gen.sv
// Bench for led_tick_gen at HALF=5, STRETCH_TICKS=2. A behavioural model
// expressed in terms of enabled-edge count predicts each cycle's outputs,
// which are queued at drive time and compared once the edge has happened.
module tb_led_tick_gen;

    localparam int unsigned HALF = 5;
    localparam int unsigned STR  = 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic ENABLE = 1'b0;
    logic TX_ACT_IN = 1'b0;
    logic RX_ACT_IN = 1'b0;
    logic CLK_10HZ, TICK_10HZ, TICK_1HZ, TX_ACT_LED, RX_ACT_LED;

    led_tick_gen #(
        .CLK_FREQ_HZ  (100),
        .TICK_HZ      (10),
        .STRETCH_TICKS(STR)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ENABLE    (ENABLE),
        .TX_ACT_IN (TX_ACT_IN),
        .RX_ACT_IN (RX_ACT_IN),
        .CLK_10HZ  (CLK_10HZ),
        .TICK_10HZ (TICK_10HZ),
        .TICK_1HZ  (TICK_1HZ),
        .TX_ACT_LED(TX_ACT_LED),
        .RX_ACT_LED(RX_ACT_LED)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard of expected {CLK_10HZ, TICK_10HZ, TICK_1HZ, TX_ACT_LED, RX_ACT_LED}
    logic [4:0] sb_q[$];

    // Model state: enabled edges since reset, stretch counts, last tick seen
    int m_e   = 0;
    int m_tx  = 0;
    int m_rx  = 0;
    bit m_t10 = 1'b0;

    // Drive one edge, predict its outcome, queue it, and wait past the edge
    task automatic step(input bit rst, input bit en, input bit tx, input bit rx);
        bit c, t10, t1;
        RST = rst; ENABLE = en; TX_ACT_IN = tx; RX_ACT_IN = rx;
        t10 = 1'b0; t1 = 1'b0;
        if (rst) begin
            m_e = 0; m_tx = 0; m_rx = 0;
        end else begin
            if (en) begin
                m_e++;
                t10 = (m_e % HALF == 0) && ((m_e / HALF) % 2 == 1);
                t1  = (m_e % (20 * HALF) == 19 * HALF);
            end
            if (tx) m_tx = STR; else if (m_t10 && m_tx > 0) m_tx--;
            if (rx) m_rx = STR; else if (m_t10 && m_rx > 0) m_rx--;
        end
        c = ((m_e / HALF) % 2 == 1);
        m_t10 = t10;
        sb_q.push_back({c, t10, t1, m_tx != 0, m_rx != 0});
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {CLK_10HZ, TICK_10HZ, TICK_1HZ, TX_ACT_LED, RX_ACT_LED};
    endfunction

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        void'(sb_q.pop_front());
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp = sb_q.pop_front();
            n_total++;
            if (outs() !== exp) $display("FAIL reset_sb[%0d]: got %b exp %b", i, outs(), exp);
            else n_pass++;
        end
        n_total++;
        if (outs() !== 5'b0) $display("FAIL reset_zero: got %b exp 00000", outs());
        else n_pass++;
    endtask

    task automatic test_free_run();
        logic [4:0] exp;
        do_reset();
        for (int n = 1; n <= 200; n++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            exp = sb_q.pop_front();
            n_total++;
            if (outs() !== exp) $display("FAIL free_run edge %0d: got %b exp %b", n, outs(), exp);
            else n_pass++;
            if (n == 4 || n == 5 || n == 10) begin
                n_total++;
                if (CLK_10HZ !== (n == 5)) $display("FAIL free_clk edge %0d: got %b exp %b", n, CLK_10HZ, n == 5);
                else n_pass++;
            end
            if (n == 95 || n == 195) begin
                n_total++;
                if ({TICK_1HZ, TICK_10HZ} !== 2'b11) $display("FAIL free_1hz edge %0d: got %b exp 11", n, {TICK_1HZ, TICK_10HZ});
                else n_pass++;
            end
        end
    endtask

    task automatic test_enable_gate();
        logic [4:0] exp;
        do_reset();
        for (int n = 1; n <= 14; n++) begin
            step(1'b0, !(n >= 2 && n <= 4), 1'b0, 1'b0);
            exp = sb_q.pop_front();
            n_total++;
            if (outs() !== exp) $display("FAIL enable_gate edge %0d: got %b exp %b", n, outs(), exp);
            else n_pass++;
            if (n == 7 || n == 8) begin
                n_total++;
                if ({CLK_10HZ, TICK_10HZ} !== {2{n == 8}}) $display("FAIL enable_rise edge %0d: got %b", n, {CLK_10HZ, TICK_10HZ});
                else n_pass++;
            end
        end
    endtask

    task automatic test_tx_stretch();
        logic [4:0] exp;
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            step(1'b0, 1'b1, n == 7, 1'b0);
            exp = sb_q.pop_front();
            n_total++;
            if (outs() !== exp) $display("FAIL tx_stretch edge %0d: got %b exp %b", n, outs(), exp);
            else n_pass++;
            if (n == 7 || n == 16 || n == 25 || n == 26) begin
                n_total++;
                if ({TX_ACT_LED, RX_ACT_LED} !== {n != 26, 1'b0}) $display("FAIL tx_led edge %0d: got %b", n, {TX_ACT_LED, RX_ACT_LED});
                else n_pass++;
            end
        end
    endtask

    task automatic test_rx_reload();
        logic [4:0] exp;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            step(1'b0, 1'b1, 1'b0, n == 16);
            exp = sb_q.pop_front();
            n_total++;
            if (outs() !== exp) $display("FAIL rx_reload edge %0d: got %b exp %b", n, outs(), exp);
            else n_pass++;
            if (n == 35 || n == 36) begin
                n_total++;
                if (RX_ACT_LED !== (n == 35)) $display("FAIL rx_led edge %0d: got %b exp %b", n, RX_ACT_LED, n == 35);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp;
        do_reset();
        for (int n = 1; n <= 7; n++) begin
            step(1'b0, 1'b1, n == 6, 1'b0);
            void'(sb_q.pop_front());
        end
        n_total++;
        if ({CLK_10HZ, TX_ACT_LED} !== 2'b11) $display("FAIL mid_pre: got %b exp 11", {CLK_10HZ, TX_ACT_LED});
        else n_pass++;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        exp = sb_q.pop_front();
        n_total++;
        if (outs() !== 5'b0 || exp !== 5'b0) $display("FAIL mid_reset: got %b exp 00000", outs());
        else n_pass++;
        for (int n = 1; n <= 12; n++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            exp = sb_q.pop_front();
            n_total++;
            if (outs() !== exp) $display("FAIL mid_after edge %0d: got %b exp %b", n, outs(), exp);
            else n_pass++;
            if (n == 4 || n == 5 || n == 10) begin
                n_total++;
                if (CLK_10HZ !== (n == 5)) $display("FAIL mid_clk edge %0d: got %b exp %b", n, CLK_10HZ, n == 5);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        int errs;
        errs = 0;
        do_reset();
        for (int n = 1; n <= 400; n++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0);
            exp = sb_q.pop_front();
            n_total++;
            if (outs() !== exp) begin
                errs++;
                if (errs <= 10) $display("FAIL random edge %0d: got %b exp %b", n, outs(), exp);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_enable_gate();
        test_tx_stretch();
        test_rx_reload();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
